// File: rtl/bk_pipe_adder_pkg.sv
// bk_pkg: shared types and helpers for the pipelined Brent-Kung adder.
//   pg_t          generate/propagate pair for one bit or bit group
//   clog2         ceiling log2 usable in constant expressions
//   nlev          Brent-Kung prefix depth for a given width
//   ngroups       number of register-separated prefix groups
//   latency       accept-to-out_valid latency in cycles
//   black / grey  prefix combine cells (grey produces only a valid g)
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int nlev(input int width);
        return 2 * clog2(width) - 1;
    endfunction

    function automatic int ngroups(input int width, input int reg_levels);
        return (nlev(width) + reg_levels - 1) / reg_levels;
    endfunction

    function automatic int latency(input int width, input int reg_levels);
        return 2 + ngroups(width, reg_levels);
    endfunction

    function automatic pg_t black(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Used where the lower group already reaches bit 0: the result is a final
    // carry, so its group propagate is never consumed downstream.
    function automatic pg_t grey(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_pipe_adder_if.sv
// bk_pipe_adder_if: operand/result streams of the pipelined adder.
//   in_*   operand beat (valid/ready), A, B, carry-in, subtract select, tag
//   out_*  result beat (valid/ready), sum, carry-out, signed overflow, tag
//   master: producer/consumer side   slave: adder side
interface bk_pipe_adder_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
    );
endinterface

// File: rtl/bk_pipe_adder_prefix_level.sv
// bk_prefix_level: one combinational Brent-Kung prefix level.
//   pg_in   group generate/propagate per bit entering the level
//   pg_out  group generate/propagate per bit leaving the level
// Levels 0..LOG-1 form the up-sweep (span doubles each level); the remaining
// LOG-1 levels form the down-sweep that fills in the skipped positions.
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  pg_t [WIDTH-1:0] pg_in,
    output pg_t [WIDTH-1:0] pg_out
);
    localparam int LOG  = clog2(WIDTH);
    localparam bit UP   = LEVEL < LOG;
    localparam int D    = UP ? LEVEL : 2 * LOG - 2 - LEVEL;
    localparam int SPAN = 1 << D;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (UP && ((i + 1) % (2 * SPAN) == 0)) begin : g_up
            if (i + 1 == 2 * SPAN) begin : g_final
                assign pg_out[i] = grey(pg_in[i], pg_in[i - SPAN]);
            end else begin : g_group
                assign pg_out[i] = black(pg_in[i], pg_in[i - SPAN]);
            end
        end else if (!UP && ((i + 1) % (2 * SPAN) == SPAN) && (i >= 2 * SPAN)) begin : g_down
            assign pg_out[i] = grey(pg_in[i], pg_in[i - SPAN]);
        end else begin : g_pass
            assign pg_out[i] = pg_in[i];
        end
    end
endmodule

// File: rtl/bk_pipe_adder.sv
// bk_pipe_adder: pipelined Brent-Kung adder/subtractor with valid/ready flow.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     slave side of bk_pipe_adder_if:
//           in_valid/in_ready/in_a/in_b/in_cin/in_sub/in_tag operand beat,
//           out_valid/out_ready/out_sum/out_cout/out_ovf/out_tag result beat
// Stage 0 registers P/G, a register follows every REG_LEVELS prefix levels,
// and the final stage registers the result, giving latency(WIDTH, REG_LEVELS).
// The whole pipe advances on one global enable; bubbles are not collapsed.
module bk_pipe_adder
    import bk_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REG_LEVELS = 2,
    parameter int TAG_W      = 4
) (
    input logic             clk,
    input logic             rst_n,
    bk_pipe_adder_if.slave  bus
);
    localparam int NLEV = nlev(WIDTH);
    localparam int NGRP = ngroups(WIDTH, REG_LEVELS);

    // Reset asserts immediately but releases two clocks later, so no flop
    // leaves reset on an edge too close to the external deassertion.
    logic [1:0] rst_sync;
    logic       rst_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_ok = rst_sync[1];

    logic en;
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en && rst_ok;

    logic [WIDTH-1:0] b_eff;
    pg_t  [WIDTH-1:0] pg_in;

    assign b_eff = bus.in_b ^ {WIDTH{bus.in_sub}};

    // Carry-in is folded into bit 0 as G[-1], so the prefix tree itself
    // needs no extra position.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pg_in[i].g = bus.in_a[i] & b_eff[i];
            pg_in[i].p = bus.in_a[i] ^ b_eff[i];
        end
        pg_in[0].g = (bus.in_a[0] & b_eff[0]) | ((bus.in_a[0] ^ b_eff[0]) & bus.in_cin);
    end

    logic [NGRP:0]      v_q;
    logic [NGRP:0]      cin_q;
    pg_t  [WIDTH-1:0]   pg_q  [0:NGRP];
    logic [WIDTH-1:0]   p_q   [0:NGRP];
    logic [TAG_W-1:0]   tag_q [0:NGRP];
    pg_t  [WIDTH-1:0]   lv    [1:NLEV];

    // Each group starts from the register of the previous group.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        pg_t [WIDTH-1:0] src;
        if (l % REG_LEVELS == 0) begin : g_from_reg
            assign src = pg_q[l / REG_LEVELS];
        end else begin : g_from_lvl
            assign src = lv[l];
        end
        bk_prefix_level #(.WIDTH(WIDTH), .LEVEL(l)) u_lvl (
            .pg_in  (src),
            .pg_out (lv[l + 1])
        );
    end

    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] fin_p_unused;

    // Final group generates are the carries out of each bit position.
    always_comb begin
        c[0] = cin_q[NGRP];
        for (int i = 1; i < WIDTH; i++) c[i] = pg_q[NGRP][i - 1].g;
        for (int i = 0; i < WIDTH; i++) fin_p_unused[i] = pg_q[NGRP][i].p;
        sum  = p_q[NGRP] ^ c;
        cout = pg_q[NGRP][WIDTH - 1].g;
    end

    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            v_q   <= '0;
            cin_q <= '0;
            for (int s = 0; s <= NGRP; s++) begin
                pg_q[s]  <= '0;
                p_q[s]   <= '0;
                tag_q[s] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_tag   <= '0;
        end else if (en) begin
            v_q      <= {v_q[NGRP-1:0], bus.in_valid};
            cin_q    <= {cin_q[NGRP-1:0], bus.in_cin};
            pg_q[0]  <= pg_in;
            p_q[0]   <= bus.in_a ^ b_eff;
            tag_q[0] <= bus.in_tag;
            for (int s = 1; s <= NGRP; s++) begin
                pg_q[s]  <= lv[(s * REG_LEVELS < NLEV) ? s * REG_LEVELS : NLEV];
                p_q[s]   <= p_q[s - 1];
                tag_q[s] <= tag_q[s - 1];
            end
            bus.out_valid <= v_q[NGRP];
            bus.out_sum   <= sum;
            bus.out_cout  <= cout;
            bus.out_ovf   <= c[WIDTH - 1] ^ cout;
            bus.out_tag   <= tag_q[NGRP];
        end
    end
endmodule
